rob_entry_allocator: RTL
========================

# rob_entry_allocator

Dispatch-side allocator for reorder-buffer entries, one stage upstream of the single-issue ROB. Each cycle it grants up to two consecutive ROB entry addresses to the dispatch group, keeping the allocation pointer and the free-entry count. Entries return when the ROB reports commits. A branch-mispredict flush squashes every in-flight entry. The produced `dp1/dp2` strobes and addresses drive the ROB's dispatch write ports directly.

## Interface
Parameters:
- `ROB_NUM`, 64: physical ROB entries. Address 0 is never allocated, so usable capacity is `ROB_NUM-1`.
- `ROB_SEL`, 6: entry address width (log2 `ROB_NUM`).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: reset, asynchronous, active-high.
- `dp_req_num_i` in 2: instructions requesting entries this cycle (0, 1 or 2). The value 3 is illegal and is flagged by an assertion.
- `stall_dp_i` in 1: external dispatch stall. Suppresses any grant.
- `prmiss_i` in 1: mispredict flush.
- `comnum_i` in 1: entries retired by the ROB this cycle.
- `commit_ptr_i` in `ROB_SEL`: current ROB commit pointer.
- `dp1_o` out 1: slot-0 grant.
- `dp2_o` out 1: slot-1 grant.
- `dp1_addr_o` out `ROB_SEL`: slot-0 entry address.
- `dp2_addr_o` out `ROB_SEL`: slot-1 entry address.
- `alloc_stall_o` out 1: request exceeds free entries.
- `freenum_o` out `ROB_SEL`: current free-entry count, range 0..63.
- `rrfptr_o` out `ROB_SEL`: next address to allocate.

## Operation
- **Wrap rule `nxt(p)`:** `p+1`, except 63 goes to 1. Address 0 is skipped, matching the ROB commit-pointer wrap.
- **Slot addresses:**
  - `dp1_addr_o = rrfptr`.
  - `dp2_addr_o = nxt(rrfptr)`.
  - Both are always driven, regardless of grant.
- **Grant:** `grant = (req!=0) & ~stall_dp_i & ~prmiss_i & (freenum >= req)`.
  - `dp1_o = grant`.
  - `dp2_o = grant & (req==2)`.
  - All-or-nothing: a 2-request is never partially granted.
- **Stall flag:** `alloc_stall_o = (req!=0) & (freenum < req)`. It is independent of `stall_dp_i` and `prmiss_i`.
- **Allocation count:** `a = grant ? req : 0`.
- **Pointer update:** `rrfptr <= rrfptr + a`, minus 63 when the sum exceeds 63. The result is always in 1..63.
- **Count update:** `freenum <= freenum - a + comnum_i`. Width rule: evaluate in `ROB_SEL+1` bits. The result never exceeds 63.
- **Flush:** when `prmiss_i` is high it takes priority over allocation.
  - `rrfptr <= nxt-advance(commit_ptr_i, comnum_i)`.
  - `freenum <= 63`.
  - The same cycle's commit is honoured; every uncommitted entry is squashed.
- **Illegal conditions (assertions):**
  - `comnum_i` while `freenum==63`.
  - `dp_req_num_i==3`.
  - State is left unchanged by neither of these; only the checker flags them.

## Timing
- **Reset values:** `rrfptr=1`, `freenum=63`.
  - `rrfptr_o=1`, `freenum_o=63`.
  - `dp1_addr_o=1`, `dp2_addr_o=2`.
  - `dp1_o=dp2_o=alloc_stall_o=0` while the request is 0.
- **Output paths:**
  - Grants and the stall flag are combinational from inputs plus registered state: zero-cycle latency.
  - Addresses and `freenum_o` are registered-state outputs.
- **State timing:** state updates on the rising edge after the grant. A back-to-back grant in the next cycle sees the advanced pointer.
- **Simultaneous commit and allocation:** legal. When `freenum==0`, a same-cycle commit does not enable a grant; it becomes visible next cycle.
- **Reset mid-operation:** asynchronous return to reset values. No partially-updated state survives.

## Structure
- `ROB_NUM`, `ROB_SEL` and a new `ROB_CAP` (`ROB_NUM-1`) belong in `consts/Consts.vh`, shared with the ROB.
- One sub-module, `rob_ptr_adv`: combinational wrap-aware adder, `p + n` with n in 0..2 under the skip-zero rule. It is instantiated for `dp2_addr_o`, the pointer update and the flush pointer.

## Test plan
- **Reset:** assert `reset_i` asynchronously mid-cycle -> `rrfptr_o=1`, `freenum_o=63`, `dp2_addr_o=2`, grants 0.
- **Fill:** 63 single requests, no commits -> addresses 1..63 granted in order, `freenum_o=0`. The 64th request gives `dp1_o=0`, `alloc_stall_o=1`.
- **Partial space:** `freenum=1`, `req=2` -> `dp1_o=dp2_o=0`, `alloc_stall_o=1`. With `req=1` instead -> grant, `freenum_o=0`.
- **Wrap:** `rrfptr=63`, `req=2` granted -> `dp1_addr_o=63`, `dp2_addr_o=1`. Next cycle `rrfptr_o=2`.
- **Overlap:** `freenum=10`, `req=2` with `comnum_i=1` -> `freenum_o=9`. With `stall_dp_i=1` instead -> no grant, `freenum_o=11`.
- **Flush:** `prmiss_i=1`, `commit_ptr_i=63`, `comnum_i=1`, `req=2` -> no grant, `rrfptr_o=1`, `freenum_o=63`.

Source files
------------

// File: rtl/rob_entry_allocator_pkg.sv
// Shared ROB sizing constants and dispatch-count type used by the allocator and the ROB.
package rob_entry_allocator_pkg;

  localparam int unsigned ROB_NUM = 64;
  localparam int unsigned ROB_SEL = 6;
  // Address 0 is reserved, so one physical entry is never usable.
  localparam int unsigned ROB_CAP = ROB_NUM - 1;

  typedef logic [1:0] dp_num_t;

endpackage

// File: rtl/rob_entry_allocator_ptr_adv.sv
// Wrap-aware ROB pointer adder: p + n (n in 0..2), skipping address 0 on wrap.
module rob_ptr_adv #(
  parameter int unsigned ROB_SEL = 6,
  parameter int unsigned ROB_CAP = 63
) (
  input  logic [ROB_SEL-1:0] p,
  input  logic [1:0]         n,
  output logic [ROB_SEL-1:0] q
);

  logic [ROB_SEL:0] raw;

  always_comb begin
    raw = {1'b0, p} + (ROB_SEL+1)'(n);
    if (raw > (ROB_SEL+1)'(ROB_CAP)) begin
      q = ROB_SEL'(raw - (ROB_SEL+1)'(ROB_CAP));
    end else begin
      q = ROB_SEL'(raw);
    end
  end

endmodule

// File: rtl/rob_entry_allocator.sv
// Dispatch-side ROB entry allocator: grants up to two consecutive entries per cycle,
// tracks the allocation pointer and free count, and rewinds on mispredict flush.
module rob_entry_allocator #(
  parameter int unsigned ROB_NUM = rob_entry_allocator_pkg::ROB_NUM,
  parameter int unsigned ROB_SEL = rob_entry_allocator_pkg::ROB_SEL
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         dp_req_num_i,
  input  logic               stall_dp_i,
  input  logic               prmiss_i,
  input  logic               comnum_i,
  input  logic [ROB_SEL-1:0] commit_ptr_i,
  output logic               dp1_o,
  output logic               dp2_o,
  output logic [ROB_SEL-1:0] dp1_addr_o,
  output logic [ROB_SEL-1:0] dp2_addr_o,
  output logic               alloc_stall_o,
  output logic [ROB_SEL-1:0] freenum_o,
  output logic [ROB_SEL-1:0] rrfptr_o
);

  import rob_entry_allocator_pkg::*;

  localparam int unsigned Cap = ROB_NUM - 1;

  logic [ROB_SEL-1:0] rrfptr_q, rrfptr_d;
  logic [ROB_SEL-1:0] freenum_q, freenum_d;
  logic [ROB_SEL-1:0] ptr_alloc, ptr_flush;
  logic               req_any, space_ok, grant;
  dp_num_t            alloc_num;

  assign req_any  = (dp_req_num_i != 2'd0);
  assign space_ok = (freenum_q >= ROB_SEL'(dp_req_num_i));
  assign grant    = req_any & ~stall_dp_i & ~prmiss_i & space_ok;

  assign alloc_num = grant ? dp_num_t'(dp_req_num_i) : dp_num_t'(2'd0);

  assign dp1_o         = grant;
  assign dp2_o         = grant & (dp_req_num_i == 2'd2);
  assign alloc_stall_o = req_any & ~space_ok;

  assign dp1_addr_o = rrfptr_q;
  assign freenum_o  = freenum_q;
  assign rrfptr_o   = rrfptr_q;

  rob_ptr_adv #(
    .ROB_SEL (ROB_SEL),
    .ROB_CAP (Cap)
  ) u_adv_dp2 (
    .p (rrfptr_q),
    .n (2'd1),
    .q (dp2_addr_o)
  );

  rob_ptr_adv #(
    .ROB_SEL (ROB_SEL),
    .ROB_CAP (Cap)
  ) u_adv_alloc (
    .p (rrfptr_q),
    .n (alloc_num),
    .q (ptr_alloc)
  );

  // Flush restarts allocation just past the last entry committed this cycle.
  rob_ptr_adv #(
    .ROB_SEL (ROB_SEL),
    .ROB_CAP (Cap)
  ) u_adv_flush (
    .p (commit_ptr_i),
    .n ({1'b0, comnum_i}),
    .q (ptr_flush)
  );

  always_comb begin
    rrfptr_d  = ptr_alloc;
    freenum_d = ROB_SEL'({1'b0, freenum_q} - (ROB_SEL+1)'(alloc_num)
                         + (ROB_SEL+1)'(comnum_i));
    if (prmiss_i) begin
      rrfptr_d  = ptr_flush;
      freenum_d = ROB_SEL'(Cap);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rrfptr_q  <= ROB_SEL'(1);
      freenum_q <= ROB_SEL'(Cap);
    end else begin
      rrfptr_q  <= rrfptr_d;
      freenum_q <= freenum_d;
    end
  end

  a_no_req3 : assert property (@(posedge clk_i) disable iff (reset_i)
    dp_req_num_i != 2'd3);

  a_no_commit_when_empty : assert property (@(posedge clk_i) disable iff (reset_i)
    !(comnum_i && (freenum_q == ROB_SEL'(Cap))));

endmodule
